// File: rtl/packet_router.sv
// 1-to-N packet router: framed input packets are copied into one fall-through FIFO
// per destination bit of the header mask; zero-mask packets are dropped and counted.
module packet_router #(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_W-1:0]             in_data,
    input  logic                          in_sop,
    input  logic                          in_eop,
    output logic [NUM_PORTS-1:0]          out_valid,
    input  logic [NUM_PORTS-1:0]          out_ready,
    output logic [NUM_PORTS*DATA_W-1:0]   out_data,
    output logic [NUM_PORTS-1:0]          out_sop,
    output logic [NUM_PORTS-1:0]          out_eop,
    output logic [15:0]                   drop_cnt,
    output logic                          proto_err,
    output logic [1:0]                    dbg_state
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    // Handshake: an input word moves on a rising edge where in_valid && in_ready;
    // an output word is popped on an edge where out_valid[p] && out_ready[p].
    // in_ready depends only on state, mask, header bits and FIFO fill, never on in_valid.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t                 state, state_nx;
    logic [NUM_PORTS-1:0]   mask, mask_nx;
    logic [NUM_PORTS-1:0]   hdr_mask;
    logic [NUM_PORTS-1:0]   full;
    logic [NUM_PORTS-1:0]   push;
    logic [NUM_PORTS-1:0]   pop;
    logic                   push_sop;
    logic                   err_nx;
    logic                   drop_inc;

    assign hdr_mask  = in_data[NUM_PORTS-1:0];
    assign dbg_state = state;

    always_comb begin
        state_nx = state;
        mask_nx  = mask;
        in_ready = 1'b1;
        push     = '0;
        push_sop = 1'b0;
        err_nx   = 1'b0;
        drop_inc = 1'b0;
        case (state)
            IDLE: begin
                if (in_sop) begin
                    if (hdr_mask != '0) begin
                        // A port is a blocker only if the packet targets it.
                        in_ready = &(~full | ~hdr_mask);
                        if (in_valid && in_ready) begin
                            push     = hdr_mask;
                            push_sop = 1'b1;
                            mask_nx  = hdr_mask;
                            state_nx = in_eop ? IDLE : FWD;
                        end
                    end else if (in_valid) begin
                        drop_inc = 1'b1;
                        state_nx = in_eop ? IDLE : DROP;
                    end
                end else if (in_valid) begin
                    err_nx = 1'b1;
                end
            end
            FWD: begin
                in_ready = &(~full | ~mask);
                if (in_valid && in_ready) begin
                    push   = mask;
                    err_nx = in_sop;
                    if (in_eop) begin
                        state_nx = IDLE;
                        mask_nx  = '0;
                    end
                end
            end
            DROP: begin
                if (in_valid) begin
                    err_nx = in_sop;
                    if (in_eop) state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
                mask_nx  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            mask      <= '0;
            proto_err <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            state     <= state_nx;
            mask      <= mask_nx;
            proto_err <= err_nx;
            if (drop_inc && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
        end
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_fifo
        logic [DATA_W+1:0] mem [FIFO_DEPTH];
        logic [AW-1:0]     wr_ptr;
        logic [AW-1:0]     rd_ptr;
        logic [CW-1:0]     count;
        logic [DATA_W+1:0] head;

        assign full[p]      = (count == CW'(FIFO_DEPTH));
        assign out_valid[p] = (count != '0);
        assign pop[p]       = out_valid[p] & out_ready[p];
        assign head         = mem[rd_ptr];

        assign out_data[p*DATA_W +: DATA_W] = head[DATA_W-1:0];
        assign out_sop[p]                   = head[DATA_W+1];
        assign out_eop[p]                   = head[DATA_W];

        // Storage is left out of reset; only the pointers define what is valid.
        always_ff @(posedge clk) begin
            if (push[p]) mem[wr_ptr] <= {push_sop, in_eop, in_data};
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push[p]) wr_ptr <= wr_ptr + AW'(1);
                if (pop[p])  rd_ptr <= rd_ptr + AW'(1);
                if (push[p] && !pop[p])      count <= count + CW'(1);
                else if (pop[p] && !push[p]) count <= count - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_packet_router.sv
// Directed bench for packet_router: hand-written packets, per-port expected queues
// filled by the stimulus and drained by a negedge monitor.
module tb_packet_router;

    localparam int NP = 4;
    localparam int DW = 8;

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [DW-1:0]     in_data;
    logic              in_sop;
    logic              in_eop;
    logic [NP-1:0]     out_valid;
    logic [NP-1:0]     out_ready;
    logic [NP*DW-1:0]  out_data;
    logic [NP-1:0]     out_sop;
    logic [NP-1:0]     out_eop;
    logic [15:0]       drop_cnt;
    logic              proto_err;
    logic [1:0]        dbg_state;

    int tests_run = 0;
    int fails     = 0;
    int pe_cnt    = 0;

    logic [DW+1:0] exp_q [NP][$];

    packet_router #(.NUM_PORTS(NP), .DATA_W(DW), .FIFO_DEPTH(16)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_sop(in_sop), .in_eop(in_eop),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sop(out_sop), .out_eop(out_eop),
        .drop_cnt(drop_cnt), .proto_err(proto_err), .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200us;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // scoreboard monitor: inputs change at negedge, so +2 sees what the next edge uses
    always @(negedge clk) begin
        #2;
        if (!reset) begin
            if (proto_err) pe_cnt++;
            for (int p = 0; p < NP; p++) begin
                if (out_valid[p] && out_ready[p]) begin
                    if (exp_q[p].size() == 0)
                        check($sformatf("unexpected_p%0d", p),
                              {22'd0, out_sop[p], out_eop[p], out_data[p*DW +: DW]}, 32'hFFFF_FFFF);
                    else
                        check($sformatf("word_p%0d", p),
                              {22'd0, out_sop[p], out_eop[p], out_data[p*DW +: DW]},
                              {22'd0, exp_q[p].pop_front()});
                end
            end
        end
    end

    // driver tasks
    task automatic expect_word(input logic [NP-1:0] m, input logic [DW-1:0] d,
                               input logic s, input logic e);
        for (int p = 0; p < NP; p++)
            if (m[p]) exp_q[p].push_back({s, e, d});
    endtask

    task automatic send(input logic [DW-1:0] d, input logic s, input logic e);
        int n;
        n = 0;
        in_data  = d;
        in_sop   = s;
        in_eop   = e;
        in_valid = 1'b1;
        #1;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!in_ready) check("send_timeout", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size()) != 0
               && n < 500) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        for (int p = 0; p < NP; p++)
            check($sformatf("%s_left_p%0d", tag, p), exp_q[p].size(), 0);
        check({tag, "_out_valid"}, {28'd0, out_valid}, 32'd0);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_sop    = 1'b0;
        in_eop    = 1'b0;
        out_ready = '1;
        repeat (3) @(negedge clk);
        check("rst_out_valid", {28'd0, out_valid}, 32'd0);
        check("rst_drop_cnt", {16'd0, drop_cnt}, 32'd0);
        check("rst_proto_err", {31'd0, proto_err}, 32'd0);
        check("rst_state", {30'd0, dbg_state}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // T1: unicast to port 2
        expect_word(4'b0100, 8'h04, 1'b1, 1'b0);
        expect_word(4'b0100, 8'hA1, 1'b0, 1'b0);
        expect_word(4'b0100, 8'hA2, 1'b0, 1'b1);
        send(8'h04, 1'b1, 1'b0);
        send(8'hA1, 1'b0, 1'b0);
        send(8'hA2, 1'b0, 1'b1);
        drain("t1");

        // T2: multicast to ports 0 and 2
        expect_word(4'b0101, 8'h05, 1'b1, 1'b0);
        expect_word(4'b0101, 8'hB1, 1'b0, 1'b0);
        expect_word(4'b0101, 8'hB2, 1'b0, 1'b0);
        expect_word(4'b0101, 8'hB3, 1'b0, 1'b1);
        send(8'h05, 1'b1, 1'b0);
        send(8'hB1, 1'b0, 1'b0);
        send(8'hB2, 1'b0, 1'b0);
        send(8'hB3, 1'b0, 1'b1);
        drain("t2");
        check("t2_no_proto_err", pe_cnt, 0);

        // T3: fill port 1 to depth, then one pop admits the 17th word
        out_ready[1] = 1'b0;
        expect_word(4'b0010, 8'h02, 1'b1, 1'b0);
        send(8'h02, 1'b1, 1'b0);
        for (int i = 1; i < 16; i++) begin
            expect_word(4'b0010, 8'h10 + 8'(i), 1'b0, 1'b0);
            send(8'h10 + 8'(i), 1'b0, 1'b0);
        end
        expect_word(4'b0010, 8'h2F, 1'b0, 1'b1);
        in_data  = 8'h2F;
        in_sop   = 1'b0;
        in_eop   = 1'b1;
        in_valid = 1'b1;
        #1;
        check("t3_full_in_ready", {31'd0, in_ready}, 32'd0);
        check("t3_full_out_valid", {28'd0, out_valid}, 32'h2);
        out_ready[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready[1] = 1'b0;
        #1;
        check("t3_after_pop_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_eop   = 1'b0;
        out_ready[1] = 1'b1;
        drain("t3");

        // T4: zero-mask drop (with a stray sop inside), then normal routing
        send(8'h00, 1'b1, 1'b0);
        send(8'hD1, 1'b1, 1'b0);
        send(8'hD2, 1'b0, 1'b1);
        @(negedge clk);
        check("t4_drop_cnt", {16'd0, drop_cnt}, 32'd1);
        check("t4_state_idle", {30'd0, dbg_state}, 32'd0);
        check("t4_drop_sop_err", pe_cnt, 1);
        expect_word(4'b1000, 8'h08, 1'b1, 1'b0);
        expect_word(4'b1000, 8'hE1, 1'b0, 1'b1);
        send(8'h08, 1'b1, 1'b0);
        send(8'hE1, 1'b0, 1'b1);
        drain("t4");

        // T5: headerless word in IDLE
        send(8'h55, 1'b0, 1'b1);
        check("t5_err_pulse", {31'd0, proto_err}, 32'd1);
        @(negedge clk);
        check("t5_err_cleared", {31'd0, proto_err}, 32'd0);
        check("t5_drop_cnt", {16'd0, drop_cnt}, 32'd1);
        check("t5_out_valid", {28'd0, out_valid}, 32'd0);

        // T7: sop inside FWD is forwarded as plain data
        expect_word(4'b0010, 8'h02, 1'b1, 1'b0);
        expect_word(4'b0010, 8'hC1, 1'b0, 1'b0);
        expect_word(4'b0010, 8'hC2, 1'b0, 1'b1);
        send(8'h02, 1'b1, 1'b0);
        send(8'hC1, 1'b1, 1'b0);
        send(8'hC2, 1'b0, 1'b1);
        drain("t7");
        check("t7_err_total", pe_cnt, 3);

        // T6: reset with a partial packet queued
        out_ready = '0;
        send(8'h01, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) send(8'h60 + 8'(i), 1'b0, 1'b0);
        check("t6_queued_valid", {28'd0, out_valid}, 32'h1);
        check("t6_state_fwd", {30'd0, dbg_state}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("t6_rst_out_valid", {28'd0, out_valid}, 32'd0);
        check("t6_rst_state", {30'd0, dbg_state}, 32'd0);
        check("t6_rst_drop_cnt", {16'd0, drop_cnt}, 32'd0);
        reset = 1'b0;
        out_ready = '1;
        expect_word(4'b0011, 8'h03, 1'b1, 1'b0);
        expect_word(4'b0011, 8'h71, 1'b0, 1'b1);
        send(8'h03, 1'b1, 1'b0);
        send(8'h71, 1'b0, 1'b1);
        drain("t6");

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
